irq_controller: RTL and testbench

- Memory-mapped interrupt controller that merges up to 8 peripheral interrupt sources (ACIA, VIA, timers) into the single active-high CPU IRQ line.
- Occupies one mmio_controller slot, using the same slot bus as via and acia: rs/we/en/din/dout.
- Provides per-source enable, level/edge mode, latched pending bits with write-1-to-clear, fixed priority vectoring (lowest index wins) and software-triggered interrupts.

---
 rtl/irq_ctrl_pkg.sv | 43 ++++
 rtl/irq_controller_if.sv | 11 +
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_controller.sv | 107 ++++++++++
 tb/tb_irq_controller.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, vector
// layout and the source-mask helper used to hide unimplemented inputs.
package irq_ctrl_pkg;

  localparam int MAX_SRC         = 8;
  localparam int VECTOR_NONE_BIT = 7;

  typedef enum logic [2:0] {
    IRQ_RAW    = 3'd0,
    IRQ_PEND   = 3'd1,
    IRQ_ENABLE = 3'd2,
    IRQ_MODE   = 3'd3,
    IRQ_ACTIVE = 3'd4,
    IRQ_VECTOR = 3'd5,
    IRQ_SWSET  = 3'd6,
    IRQ_RSVD   = 3'd7
  } irq_reg_e;

  typedef logic [MAX_SRC-1:0] src_vec_t;

  typedef struct packed {
    logic       none;
    logic [2:0] idx;
  } irq_vec_t;

  // Decoded effect of one bus write on the pending/config state.
  typedef struct packed {
    src_vec_t pend_clr;
    src_vec_t ack_clr;
    src_vec_t swset;
    logic     enable_we;
    logic     mode_we;
  } irq_wr_t;

  function automatic src_vec_t src_mask(input int n);
    src_vec_t m;
    for (int i = 0; i < MAX_SRC; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// mmio slot bus shared with via/acia: register select, strobes and data.
interface irq_controller_if;
  logic [2:0] rs;
  logic       we;
  logic       en;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output rs, output we, output en, output din, input dout);
  modport slave  (input rs, input we, input en, input din, output dout);
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder, 8 requests to
// {none, idx}; kept standalone so other arbiters can reuse it.
module irq_prio_enc
  import irq_ctrl_pkg::*;
(
  input  logic [MAX_SRC-1:0] req,
  output logic               none,
  output logic [2:0]         idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    none = 1'b1;
    idx  = 3'd0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        none = 1'b0;
        idx  = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-source enable, level/edge mode,
// W1C pending latches, software set, vectoring and a registered CPU irq.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  irq_controller_if.slave    bus,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq
);

  localparam src_vec_t VALID = src_mask(NUM_SRC);

  src_vec_t src_ext;
  src_vec_t prev_src_q;
  src_vec_t latch_q;
  src_vec_t latch_d;
  src_vec_t enable_q;
  src_vec_t mode_q;
  src_vec_t rise;
  src_vec_t pend;
  src_vec_t active;
  logic     irq_q;
  irq_wr_t  wr;
  irq_vec_t vec;

  always_comb begin
    src_ext              = '0;
    src_ext[NUM_SRC-1:0] = src;
  end

  // Bus write decode; reads never touch state because the CPU issues dummy reads.
  always_comb begin
    wr = '0;
    if (bus.en && bus.we) begin
      unique case (irq_reg_e'(bus.rs))
        IRQ_PEND:   wr.pend_clr  = bus.din & VALID;
        IRQ_ENABLE: wr.enable_we = 1'b1;
        IRQ_MODE:   wr.mode_we   = 1'b1;
        IRQ_SWSET:  wr.swset     = bus.din & VALID;
        IRQ_VECTOR: begin
          if (int'(bus.din[2:0]) < NUM_SRC) begin
            wr.ack_clr[bus.din[2:0]] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Edge-mode latches: set beats clear, and a level-mode bit forgets its latch.
  always_comb begin
    rise    = src_ext & ~prev_src_q;
    latch_d = ((latch_q & ~(wr.pend_clr | wr.ack_clr)) | rise | wr.swset)
              & mode_q & VALID;
  end

  always_comb begin
    pend   = ((mode_q & latch_q) | (~mode_q & src_ext)) & VALID;
    active = pend & enable_q;
  end

  irq_prio_enc u_prio (
    .req  (active),
    .none (vec.none),
    .idx  (vec.idx)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    if (rst) begin
      prev_src_q <= '0;
      latch_q    <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_src_q <= src_ext;
      latch_q    <= latch_d;
      irq_q      <= |active;
      if (wr.enable_we) enable_q <= bus.din & VALID;
      if (wr.mode_we)   mode_q   <= bus.din & VALID;
    end
  end

  assign irq = irq_q;

  always_comb begin
    bus.dout = '0;
    unique case (irq_reg_e'(bus.rs))
      IRQ_RAW:    bus.dout = src_ext;
      IRQ_PEND:   bus.dout = pend;
      IRQ_ENABLE: bus.dout = enable_q;
      IRQ_MODE:   bus.dout = mode_q;
      IRQ_ACTIVE: bus.dout = active;
      IRQ_VECTOR: begin
        bus.dout[VECTOR_NONE_BIT] = vec.none;
        bus.dout[2:0]             = vec.idx;
      end
      default:    bus.dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios against fixed
// expectations, then randomized traffic against a per-source reference model.
module tb_irq_controller;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src = '0;
  logic         irq;

  irq_controller_if bus ();

  irq_controller #(.NUM_SRC(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .src (src),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one entry per source, following the behavioural rules.
  bit m_enable [N];
  bit m_mode   [N];
  bit m_latch  [N];
  bit m_prev   [N];
  bit m_irq;

  function automatic bit m_pend(input int i);
    if (m_mode[i]) return m_latch[i];
    return src[i];
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    logic [7:0] r;
    r = '0;
    case (a)
      3'd0: r = src;
      3'd1: for (int i = 0; i < N; i++) r[i] = m_pend(i);
      3'd2: for (int i = 0; i < N; i++) r[i] = m_enable[i];
      3'd3: for (int i = 0; i < N; i++) r[i] = m_mode[i];
      3'd4: for (int i = 0; i < N; i++) r[i] = m_pend(i) && m_enable[i];
      3'd5: begin
        r = 8'h80;
        for (int i = 0; i < N; i++) begin
          if (m_pend(i) && m_enable[i]) begin
            r = 8'(i);
            break;
          end
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advance one clock; the model consumes the inputs as they stand before the edge.
  task automatic tick();
    bit n_latch [N];
    bit n_enable [N];
    bit n_mode [N];
    bit n_irq;
    bit wr;
    wr    = bus.en && bus.we;
    n_irq = 1'b0;
    for (int i = 0; i < N; i++) begin
      bit set_b, clr_b;
      if (m_pend(i) && m_enable[i]) n_irq = 1'b1;
      set_b = (src[i] && !m_prev[i]) || (wr && bus.rs == 3'd6 && bus.din[i]);
      clr_b = (wr && bus.rs == 3'd1 && bus.din[i]) ||
              (wr && bus.rs == 3'd5 && int'(bus.din[2:0]) == i);
      n_latch[i]  = m_mode[i] ? (set_b || (m_latch[i] && !clr_b)) : 1'b0;
      n_enable[i] = (wr && bus.rs == 3'd2) ? bus.din[i] : m_enable[i];
      n_mode[i]   = (wr && bus.rs == 3'd3) ? bus.din[i] : m_mode[i];
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      m_latch[i]  = rst ? 1'b0 : n_latch[i];
      m_enable[i] = rst ? 1'b0 : n_enable[i];
      m_mode[i]   = rst ? 1'b0 : n_mode[i];
      m_prev[i]   = rst ? 1'b0 : src[i];
    end
    m_irq = rst ? 1'b0 : n_irq;
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    bus.en = 1'b1; bus.we = 1'b1; bus.rs = a; bus.din = d;
    tick();
    bus.we = 1'b0; bus.en = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    bus.en = 1'b1; bus.we = 1'b0; bus.rs = a;
    #1;
    d = bus.dout;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    src = 8'hFF; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
    peek(3'd2, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_enable: got %h expected 00", d); end
    peek(3'd3, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_mode: got %h expected 00", d); end
    peek(3'd0, d); vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL reset_raw: got %h expected ff", d); end
    peek(3'd5, d); vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL reset_vector: got %h expected 80", d); end
    // All sources are level after reset, so PEND simply mirrors src.
    peek(3'd1, d); vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL reset_pend_level: got %h expected ff", d); end
    src = 8'h00;
    tick();
    peek(3'd1, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_pend_zero: got %h expected 00", d); end
  endtask

  task automatic test_level();
    logic [7:0] d;
    wr_reg(3'd2, 8'h01);
    src = 8'h01;
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL level_irq_on: got %b expected 1", irq); end
    peek(3'd5, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL level_vector: got %h expected 00", d); end
    wr_reg(3'd1, 8'h01);
    peek(3'd1, d); vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL level_w1c_ignored: got %h expected 01", d); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL level_irq_held: got %b expected 1", irq); end
    src = 8'h00;
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL level_irq_off: got %b expected 0", irq); end
  endtask

  task automatic test_edge();
    logic [7:0] d;
    wr_reg(3'd3, 8'h04);
    wr_reg(3'd2, 8'h04);
    src = 8'h04;
    tick();
    src = 8'h00;
    peek(3'd1, d); vectors++; if (d !== 8'h04) begin miscompares++; $display("FAIL edge_pend: got %h expected 04", d); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL edge_irq_early: got %b expected 0", irq); end
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL edge_irq_2clk: got %b expected 1", irq); end
    tick(); tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL edge_irq_sticky: got %b expected 1", irq); end
    wr_reg(3'd5, 8'h02);
    peek(3'd1, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL edge_ack_pend: got %h expected 00", d); end
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL edge_ack_irq: got %b expected 0", irq); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    wr_reg(3'd3, 8'hFF);
    wr_reg(3'd2, 8'hFF);
    src = 8'h28;
    tick();
    src = 8'h00;
    tick();
    peek(3'd5, d); vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL prio_first: got %h expected 03", d); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL prio_irq: got %b expected 1", irq); end
    wr_reg(3'd5, 8'h03);
    peek(3'd5, d); vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL prio_second: got %h expected 05", d); end
    wr_reg(3'd5, 8'h05);
    peek(3'd5, d); vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL prio_none: got %h expected 80", d); end
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL prio_irq_off: got %b expected 0", irq); end
  endtask

  task automatic test_set_clear();
    logic [7:0] d;
    src = 8'h02;
    wr_reg(3'd1, 8'h02);
    peek(3'd1, d); vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL setclr_set_wins: got %h expected 02", d); end
    src = 8'h00;
    wr_reg(3'd1, 8'hFF);
    tick();
    peek(3'd1, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL setclr_cleared: got %h expected 00", d); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL setclr_irq: got %b expected 0", irq); end
  endtask

  task automatic test_swset();
    logic [7:0] d;
    wr_reg(3'd2, 8'h00);
    wr_reg(3'd3, 8'h10);
    wr_reg(3'd6, 8'h10);
    peek(3'd1, d); vectors++; if (d !== 8'h10) begin miscompares++; $display("FAIL swset_pend: got %h expected 10", d); end
    peek(3'd6, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL swset_reads0: got %h expected 00", d); end
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL swset_masked: got %b expected 0", irq); end
    wr_reg(3'd2, 8'h10);
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL swset_unmask: got %b expected 1", irq); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    peek(3'd1, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL midrst_pend: got %h expected 00", d); end
    peek(3'd2, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL midrst_enable: got %h expected 00", d); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 2) == 0) src = N'($urandom);
      bus.en  = $urandom_range(0, 1);
      bus.we  = $urandom_range(0, 1);
      bus.rs  = 3'($urandom);
      bus.din = 8'($urandom);
      #1;
      vectors++;
      if (bus.dout !== m_read(bus.rs)) begin
        miscompares++;
        $display("FAIL rand_dout cycle %0d rs %0d: got %h expected %h", c, bus.rs, bus.dout, m_read(bus.rs));
      end
      vectors++;
      if (irq !== m_irq) begin
        miscompares++;
        $display("FAIL rand_irq cycle %0d: got %b expected %b", c, irq, m_irq);
      end
      tick();
    end
    rst = 1'b0; bus.en = 1'b0; bus.we = 1'b0;
  endtask

  initial begin
    bus.rs = '0; bus.we = 1'b0; bus.en = 1'b0; bus.din = '0;
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_set_clear();
    test_swset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
